// File: rtl/vga_text_console.sv
// Byte-stream front end for the 80x30 text-mode renderer: interprets printables and
// control codes, tracks cursor/colour, and drives the character and colour map write ports.
module vga_text_console #(
    parameter int          COLS          = 80,
    parameter int          ROWS          = 30,
    parameter logic [7:0]  DEFAULT_COLOR = 8'h70
) (
    input  logic        clk_25m,
    input  logic        rst,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic [11:0] ch_map_addr_o,
    output logic [7:0]  ch_map_data_o,
    output logic        ch_map_wen_o,
    output logic [11:0] col_map_addr_o,
    output logic [7:0]  col_map_data_o,
    output logic        col_map_wen_o,
    output logic [6:0]  cursor_col_o,
    output logic [4:0]  cursor_row_o,
    output logic        busy_o
);

    // state    | meaning
    // IDLE     | accepting bytes, printing / handling control codes
    // ESC      | next accepted byte becomes the current colour
    // CLR_LINE | blanking the row the cursor just advanced into
    // CLR_ALL  | blanking the whole screen after a form feed
    typedef enum logic [1:0] {IDLE, ESC, CLR_LINE, CLR_ALL} state_t;

    localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
    localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
    localparam logic [11:0] LINE_CNT = 12'(COLS - 1);
    localparam logic [11:0] ALL_CNT  = 12'(COLS * ROWS - 1);

    state_t      state_q;
    logic [6:0]  col_q;
    logic [4:0]  row_q;
    logic [7:0]  color_q;
    logic [11:0] clr_addr_q;
    logic [11:0] clr_cnt_q;
    logic        wen_q;
    logic [11:0] addr_q;
    logic [7:0]  ch_q;
    logic [7:0]  cdat_q;
    logic        ready_q;
    logic        busy_q;

    logic [4:0]  row_adv_d;
    logic [11:0] line_base_d;
    logic [11:0] cell_addr_d;

    // row*80 as (row<<6)+(row<<4); fits in 12 bits for every valid row
    function automatic logic [11:0] row_base(input logic [4:0] r);
        return {1'b0, r, 6'b0} + {3'b0, r, 4'b0};
    endfunction

    assign row_adv_d   = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
    assign line_base_d = row_base(row_adv_d);
    assign cell_addr_d = row_base(row_q) + {5'b0, col_q};

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            color_q    <= DEFAULT_COLOR;
            clr_addr_q <= '0;
            clr_cnt_q  <= '0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            ch_q       <= '0;
            cdat_q     <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_valid_i) begin
                        case (s_data_i)
                            8'h1B: state_q <= ESC;
                            8'h0D: col_q <= '0;
                            8'h0A: begin
                                col_q      <= '0;
                                row_q      <= row_adv_d;
                                clr_addr_q <= line_base_d;
                                clr_cnt_q  <= LINE_CNT;
                                state_q    <= CLR_LINE;
                                ready_q    <= 1'b0;
                                busy_q     <= 1'b1;
                            end
                            8'h08: begin
                                if (col_q != 7'd0) col_q <= col_q - 7'd1;
                            end
                            8'h0C: begin
                                col_q      <= '0;
                                row_q      <= '0;
                                clr_addr_q <= '0;
                                clr_cnt_q  <= ALL_CNT;
                                state_q    <= CLR_ALL;
                                ready_q    <= 1'b0;
                                busy_q     <= 1'b1;
                            end
                            default: begin
                                wen_q  <= 1'b1;
                                addr_q <= cell_addr_d;
                                ch_q   <= s_data_i;
                                cdat_q <= color_q;
                                if (col_q == COL_LAST) begin
                                    col_q      <= '0;
                                    row_q      <= row_adv_d;
                                    clr_addr_q <= line_base_d;
                                    clr_cnt_q  <= LINE_CNT;
                                    state_q    <= CLR_LINE;
                                    ready_q    <= 1'b0;
                                    busy_q     <= 1'b1;
                                end else begin
                                    col_q <= col_q + 7'd1;
                                end
                            end
                        endcase
                    end
                end
                ESC: begin
                    if (s_valid_i) begin
                        color_q <= s_data_i;
                        state_q <= IDLE;
                    end
                end
                CLR_LINE, CLR_ALL: begin
                    wen_q      <= 1'b1;
                    addr_q     <= clr_addr_q;
                    ch_q       <= 8'h20;
                    cdat_q     <= color_q;
                    clr_addr_q <= clr_addr_q + 12'd1;
                    if (clr_cnt_q == 12'd0) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q - 12'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready_o      = ready_q;
    assign busy_o         = busy_q;
    assign ch_map_addr_o  = addr_q;
    assign ch_map_data_o  = ch_q;
    assign ch_map_wen_o   = wen_q;
    assign col_map_addr_o = addr_q;
    assign col_map_data_o = cdat_q;
    assign col_map_wen_o  = wen_q;
    assign cursor_col_o   = col_q;
    assign cursor_row_o   = row_q;

endmodule

// File: tb/tb_vga_text_console.sv
// Directed bench for vga_text_console: printing, colour escape, line wrap/clear,
// row wrap, form feed with mid-clear reset, and cursor control codes.
module tb_vga_text_console;

    logic        clk_25m = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data_i = '0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [11:0] ch_map_addr_o;
    logic [7:0]  ch_map_data_o;
    logic        ch_map_wen_o;
    logic [11:0] col_map_addr_o;
    logic [7:0]  col_map_data_o;
    logic        col_map_wen_o;
    logic [6:0]  cursor_col_o;
    logic [4:0]  cursor_row_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail = 0;

    vga_text_console dut (
        .clk_25m(clk_25m), .rst(rst),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .ch_map_addr_o(ch_map_addr_o), .ch_map_data_o(ch_map_data_o), .ch_map_wen_o(ch_map_wen_o),
        .col_map_addr_o(col_map_addr_o), .col_map_data_o(col_map_data_o), .col_map_wen_o(col_map_wen_o),
        .cursor_col_o(cursor_col_o), .cursor_row_o(cursor_row_o), .busy_o(busy_o)
    );

    always #20 clk_25m = ~clk_25m;

    task automatic do_reset();
        @(negedge clk_25m);
        rst = 1'b1;
        s_valid_i = 1'b0;
        repeat (2) @(negedge clk_25m);
        rst = 1'b0;
    endtask

    // Returns at the negedge of the cycle following the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk_25m);
        s_data_i = b;
        s_valid_i = 1'b1;
        while (s_ready_o !== 1'b1 && waited < 3000) begin
            @(negedge clk_25m);
            waited++;
        end
        n_checks++;
        if (waited >= 3000) begin
            $display("FAIL send_timeout byte=%h ready never rose", b);
            n_fail++;
        end
        @(negedge clk_25m);
        s_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_25m);
        rst = 1'b1;
        repeat (2) @(negedge clk_25m);
        n_checks++;
        if (s_ready_o !== 1'b1 || busy_o !== 1'b0 || ch_map_wen_o !== 1'b0 || col_map_wen_o !== 1'b0) begin
            $display("FAIL reset_ctrl got ready=%b busy=%b wen=%b/%b want 1 0 0/0",
                     s_ready_o, busy_o, ch_map_wen_o, col_map_wen_o);
            n_fail++;
        end
        n_checks++;
        if (ch_map_addr_o !== 12'd0 || col_map_addr_o !== 12'd0 || ch_map_data_o !== 8'd0 || col_map_data_o !== 8'd0) begin
            $display("FAIL reset_bus got addr=%0d/%0d data=%h/%h want 0", ch_map_addr_o, col_map_addr_o,
                     ch_map_data_o, col_map_data_o);
            n_fail++;
        end
        n_checks++;
        if (cursor_col_o !== 7'd0 || cursor_row_o !== 5'd0) begin
            $display("FAIL reset_cursor got (%0d,%0d) want (0,0)", cursor_col_o, cursor_row_o);
            n_fail++;
        end
        rst = 1'b0;
    endtask

    task automatic test_print();
        do_reset();
        send_byte(8'h41);
        n_checks++;
        if (ch_map_wen_o !== 1'b1 || col_map_wen_o !== 1'b1 || ch_map_addr_o !== 12'd0 ||
            col_map_addr_o !== 12'd0 || ch_map_data_o !== 8'h41 || col_map_data_o !== 8'h70) begin
            $display("FAIL print_a got wen=%b/%b addr=%0d/%0d ch=%h col=%h want 1/1 0/0 41 70",
                     ch_map_wen_o, col_map_wen_o, ch_map_addr_o, col_map_addr_o, ch_map_data_o, col_map_data_o);
            n_fail++;
        end
        n_checks++;
        if (cursor_col_o !== 7'd1 || cursor_row_o !== 5'd0) begin
            $display("FAIL print_cursor got (%0d,%0d) want (1,0)", cursor_col_o, cursor_row_o);
            n_fail++;
        end
        @(negedge clk_25m);
        n_checks++;
        if (ch_map_wen_o !== 1'b0) begin
            $display("FAIL print_single got wen=%b want 0", ch_map_wen_o);
            n_fail++;
        end
    endtask

    task automatic test_color();
        do_reset();
        send_byte(8'h1B);
        n_checks++;
        if (ch_map_wen_o !== 1'b0 || s_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            $display("FAIL esc_nowrite got wen=%b ready=%b busy=%b want 0 1 0", ch_map_wen_o, s_ready_o, busy_o);
            n_fail++;
        end
        send_byte(8'h1E);
        n_checks++;
        if (ch_map_wen_o !== 1'b0 || cursor_col_o !== 7'd0) begin
            $display("FAIL color_nowrite got wen=%b col=%0d want 0 0", ch_map_wen_o, cursor_col_o);
            n_fail++;
        end
        send_byte(8'h42);
        n_checks++;
        if (ch_map_wen_o !== 1'b1 || ch_map_addr_o !== 12'd0 || ch_map_data_o !== 8'h42 || col_map_data_o !== 8'h1E) begin
            $display("FAIL color_b got wen=%b addr=%0d ch=%h col=%h want 1 0 42 1e",
                     ch_map_wen_o, ch_map_addr_o, ch_map_data_o, col_map_data_o);
            n_fail++;
        end
        send_byte(8'h1B);
        send_byte(8'h1B);
        send_byte(8'h43);
        n_checks++;
        if (ch_map_wen_o !== 1'b1 || ch_map_addr_o !== 12'd1 || ch_map_data_o !== 8'h43 || col_map_data_o !== 8'h1B) begin
            $display("FAIL color_esc_esc got wen=%b addr=%0d ch=%h col=%h want 1 1 43 1b",
                     ch_map_wen_o, ch_map_addr_o, ch_map_data_o, col_map_data_o);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        int low = 0;
        logic [7:0] ch;
        do_reset();
        s_valid_i = 1'b1;
        for (int i = 0; i < 80; i++) begin
            ch = 8'h41 + 8'(i % 26);
            s_data_i = ch;
            @(negedge clk_25m);
            if (ch_map_wen_o !== 1'b1 || ch_map_addr_o !== 12'(i) || ch_map_data_o !== ch || col_map_data_o !== 8'h70) begin
                if (bad == 0)
                    $display("FAIL b2b_write i=%0d got wen=%b addr=%0d ch=%h want 1 %0d %h",
                             i, ch_map_wen_o, ch_map_addr_o, ch_map_data_o, i, ch);
                bad++;
            end
        end
        s_valid_i = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            $display("FAIL b2b_writes got %0d bad cycles want 0", bad);
            n_fail++;
        end
        n_checks++;
        if (s_ready_o !== 1'b0 || busy_o !== 1'b1 || cursor_col_o !== 7'd0 || cursor_row_o !== 5'd1) begin
            $display("FAIL wrap_start got ready=%b busy=%b cursor=(%0d,%0d) want 0 1 (0,1)",
                     s_ready_o, busy_o, cursor_col_o, cursor_row_o);
            n_fail++;
        end
        if (s_ready_o === 1'b0) low++;
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk_25m);
            if (ch_map_wen_o !== 1'b1 || ch_map_addr_o !== 12'(80 + k) || ch_map_data_o !== 8'h20 ||
                col_map_data_o !== 8'h70) begin
                if (bad == 0)
                    $display("FAIL line_clear k=%0d got wen=%b addr=%0d ch=%h want 1 %0d 20",
                             k, ch_map_wen_o, ch_map_addr_o, ch_map_data_o, 80 + k);
                bad++;
            end
            if (s_ready_o === 1'b0) low++;
        end
        n_checks++;
        if (bad !== 0) begin
            $display("FAIL line_clear_writes got %0d bad cycles want 0", bad);
            n_fail++;
        end
        n_checks++;
        if (low !== 80) begin
            $display("FAIL ready_low_cycles got %0d want 80", low);
            n_fail++;
        end
        @(negedge clk_25m);
        n_checks++;
        if (ch_map_wen_o !== 1'b0 || s_ready_o !== 1'b1) begin
            $display("FAIL line_clear_end got wen=%b ready=%b want 0 1", ch_map_wen_o, s_ready_o);
            n_fail++;
        end
    endtask

    task automatic test_row_wrap();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 29; i++) send_byte(8'h0A);
        n_checks++;
        if (cursor_row_o !== 5'd29 || cursor_col_o !== 7'd0) begin
            $display("FAIL row29 got (%0d,%0d) want (0,29)", cursor_col_o, cursor_row_o);
            n_fail++;
        end
        send_byte(8'h0A);
        n_checks++;
        if (cursor_row_o !== 5'd0 || cursor_col_o !== 7'd0 || s_ready_o !== 1'b0) begin
            $display("FAIL row_wrap got cursor=(%0d,%0d) ready=%b want (0,0) 0",
                     cursor_col_o, cursor_row_o, s_ready_o);
            n_fail++;
        end
        for (int k = 0; k < 80; k++) begin
            @(negedge clk_25m);
            if (ch_map_wen_o !== 1'b1 || ch_map_addr_o !== 12'(k) || ch_map_data_o !== 8'h20 ||
                s_ready_o !== ((k == 79) ? 1'b1 : 1'b0)) begin
                if (bad == 0)
                    $display("FAIL wrap_clear k=%0d got wen=%b addr=%0d ch=%h ready=%b want 1 %0d 20",
                             k, ch_map_wen_o, ch_map_addr_o, ch_map_data_o, s_ready_o, k);
                bad++;
            end
        end
        n_checks++;
        if (bad !== 0) begin
            $display("FAIL wrap_clear_writes got %0d bad cycles want 0", bad);
            n_fail++;
        end
    endtask

    task automatic test_held_valid();
        do_reset();
        send_byte(8'h0A);
        s_data_i = 8'h5A;
        s_valid_i = 1'b1;
        repeat (81) @(negedge clk_25m);
        n_checks++;
        if (ch_map_wen_o !== 1'b1 || ch_map_addr_o !== 12'd80 || ch_map_data_o !== 8'h5A) begin
            $display("FAIL held_valid got wen=%b addr=%0d ch=%h want 1 80 5a",
                     ch_map_wen_o, ch_map_addr_o, ch_map_data_o);
            n_fail++;
        end
        s_valid_i = 1'b0;
        @(negedge clk_25m);
        n_checks++;
        if (ch_map_wen_o !== 1'b0 || cursor_col_o !== 7'd1 || cursor_row_o !== 5'd1) begin
            $display("FAIL held_once got wen=%b cursor=(%0d,%0d) want 0 (1,1)",
                     ch_map_wen_o, cursor_col_o, cursor_row_o);
            n_fail++;
        end
    endtask

    task automatic test_ff_full();
        int bad = 0;
        int busy_cnt = 0;
        do_reset();
        send_byte(8'h0C);
        if (busy_o === 1'b1) busy_cnt++;
        for (int k = 0; k < 2400; k++) begin
            @(negedge clk_25m);
            if (ch_map_wen_o !== 1'b1 || ch_map_addr_o !== 12'(k) || ch_map_data_o !== 8'h20 ||
                col_map_data_o !== 8'h70) begin
                if (bad == 0)
                    $display("FAIL ff_clear k=%0d got wen=%b addr=%0d ch=%h col=%h want 1 %0d 20 70",
                             k, ch_map_wen_o, ch_map_addr_o, ch_map_data_o, col_map_data_o, k);
                bad++;
            end
            if (busy_o === 1'b1) busy_cnt++;
        end
        n_checks++;
        if (bad !== 0) begin
            $display("FAIL ff_writes got %0d bad cycles want 0", bad);
            n_fail++;
        end
        n_checks++;
        if (busy_cnt !== 2400) begin
            $display("FAIL ff_busy_cycles got %0d want 2400", busy_cnt);
            n_fail++;
        end
        n_checks++;
        if (s_ready_o !== 1'b1) begin
            $display("FAIL ff_ready_return got %b want 1", s_ready_o);
            n_fail++;
        end
        @(negedge clk_25m);
        n_checks++;
        if (ch_map_wen_o !== 1'b0 || busy_o !== 1'b0) begin
            $display("FAIL ff_end got wen=%b busy=%b want 0 0", ch_map_wen_o, busy_o);
            n_fail++;
        end
    endtask

    task automatic test_ff_reset();
        int bad = 0;
        do_reset();
        send_byte(8'h1B);
        send_byte(8'h5A);
        send_byte(8'h41);
        send_byte(8'h0C);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk_25m);
            if (ch_map_wen_o !== 1'b1 || ch_map_addr_o !== 12'(k) || col_map_data_o !== 8'h5A) begin
                if (bad == 0)
                    $display("FAIL ff_color k=%0d got wen=%b addr=%0d col=%h want 1 %0d 5a",
                             k, ch_map_wen_o, ch_map_addr_o, col_map_data_o, k);
                bad++;
            end
        end
        n_checks++;
        if (bad !== 0) begin
            $display("FAIL ff_color_writes got %0d bad cycles want 0", bad);
            n_fail++;
        end
        @(negedge clk_25m);
        n_checks++;
        if (ch_map_wen_o !== 1'b1 || ch_map_addr_o !== 12'd1000) begin
            $display("FAIL ff_write1000 got wen=%b addr=%0d want 1 1000", ch_map_wen_o, ch_map_addr_o);
            n_fail++;
        end
        rst = 1'b1;
        @(negedge clk_25m);
        n_checks++;
        if (ch_map_wen_o !== 1'b0 || s_ready_o !== 1'b1 || busy_o !== 1'b0 ||
            cursor_col_o !== 7'd0 || cursor_row_o !== 5'd0) begin
            $display("FAIL ff_abort got wen=%b ready=%b busy=%b cursor=(%0d,%0d) want 0 1 0 (0,0)",
                     ch_map_wen_o, s_ready_o, busy_o, cursor_col_o, cursor_row_o);
            n_fail++;
        end
        rst = 1'b0;
        send_byte(8'h41);
        n_checks++;
        if (ch_map_wen_o !== 1'b1 || ch_map_addr_o !== 12'd0 || col_map_data_o !== 8'h70) begin
            $display("FAIL ff_abort_color got wen=%b addr=%0d col=%h want 1 0 70",
                     ch_map_wen_o, ch_map_addr_o, col_map_data_o);
            n_fail++;
        end
    endtask

    task automatic test_bs_cr();
        do_reset();
        send_byte(8'h08);
        n_checks++;
        if (ch_map_wen_o !== 1'b0 || cursor_col_o !== 7'd0 || cursor_row_o !== 5'd0) begin
            $display("FAIL bs_col0 got wen=%b cursor=(%0d,%0d) want 0 (0,0)",
                     ch_map_wen_o, cursor_col_o, cursor_row_o);
            n_fail++;
        end
        for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i));
        n_checks++;
        if (cursor_col_o !== 7'd5 || ch_map_addr_o !== 12'd4 || ch_map_data_o !== 8'h65) begin
            $display("FAIL five_chars got col=%0d addr=%0d ch=%h want 5 4 65",
                     cursor_col_o, ch_map_addr_o, ch_map_data_o);
            n_fail++;
        end
        send_byte(8'h0D);
        n_checks++;
        if (ch_map_wen_o !== 1'b0 || cursor_col_o !== 7'd0 || cursor_row_o !== 5'd0) begin
            $display("FAIL cr got wen=%b cursor=(%0d,%0d) want 0 (0,0)", ch_map_wen_o, cursor_col_o, cursor_row_o);
            n_fail++;
        end
        send_byte(8'h78);
        send_byte(8'h78);
        send_byte(8'h08);
        n_checks++;
        if (ch_map_wen_o !== 1'b0 || cursor_col_o !== 7'd1) begin
            $display("FAIL bs_col2 got wen=%b col=%0d want 0 1", ch_map_wen_o, cursor_col_o);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_print();
        test_color();
        test_back_to_back();
        test_row_wrap();
        test_held_valid();
        test_ff_full();
        test_ff_reset();
        test_bs_cr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
